dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Miss-handling controller and sequencer for the direct-mapped, write-back, write-allocate data cache: 1024 lines × 16 words × 32 bits, 17-bit word address split tag[16:14] / index[13:4] / offset[3:0]. It accepts one load/store at a time from the core, owns the tag/valid/dirty state, and drives the external single-port cache data array. On a miss it writes back a dirty victim, then refills the line from main memory over a valid/ready bus. It sits between the core load/store unit, the data-array RAM and the main-memory port.

## Interface
- `LINES`, 1024, number of cache lines
- `WORDS`, 16, words per line
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid` / `req_ready`  in / out  1  core request handshake
- `req_we`  in  1  1 = store, 0 = load
- `req_addr`  in  17  word address
- `req_wdata`  in  32  store data
- `resp_valid`  out  1  one-cycle pulse: load data valid or store done
- `resp_rdata`  out  32  load data; 0 for stores
- `da_en`, `da_we`  out  1  data-array enable / write
- `da_index`  out  10  data-array line
- `da_offset`  out  4  data-array word
- `da_wdata`  out  32  data-array write data
- `da_rdata`  in  32  data-array read data, valid 1 cycle after `da_en & !da_we`
- `mem_req_valid` / `mem_req_ready`  out / in  1  memory request handshake
- `mem_req_we`  out  1  1 = single-word write; 0 = 16-beat burst read
- `mem_req_addr`  out  17  word address; burst reads are line-aligned
- `mem_req_wdata`  out  32  write data
- `mem_rvalid`, `mem_rdata`  in  1, 32  refill beats, in offset order 0..15

## Operation
- FSM states: `IDLE`, `LOOKUP`, `WB_RD`, `WB_SEND`, `RF_REQ`, `RF_WAIT`, `RESP`.
- **IDLE.** `req_ready` = 1 only in this state. On acceptance, the request is registered and the FSM goes to `LOOKUP`.
- **LOOKUP.** Hit = `valid[idx] & tag[idx]==req_tag`.
  - Load hit: data-array read, then `RESP`.
  - Store hit: data-array write, set `dirty[idx]`, then `RESP`.
  - Miss with dirty victim: go to `WB_RD`.
  - Miss otherwise: go to `RF_REQ`.
- **Write-back (WB_RD ↔ WB_SEND).**
  - `WB_RD` reads word `cnt`.
  - `WB_SEND` holds `mem_req_valid` with `we=1`, address {old_tag, idx, cnt}, data = captured `da_rdata`, until `mem_req_ready`.
  - `cnt` 0..15; after word 15, clear `dirty[idx]` and go to `RF_REQ`.
- **Refill request (RF_REQ).** Hold `mem_req_valid`, `we=0`, address {req_tag, idx, 4'h0} until `mem_req_ready`, then go to `RF_WAIT`.
- **Refill data (RF_WAIT).** Each `mem_rvalid` beat writes `mem_rdata` to data array word `cnt` and increments `cnt`. After beat 15: tag←req_tag, valid←1, dirty←0, and return to `LOOKUP`. The replayed lookup is guaranteed to hit, so a store miss sets dirty on replay.
- **RESP.** `resp_valid` = 1 for one cycle, then `IDLE`.
- `cnt` is 4 bits and wraps 15→0 naturally; it is cleared on entry to `WB_RD`/`RF_WAIT`.
- Ignored inputs:
  - `mem_rvalid` outside `RF_WAIT`.
  - `req_valid` outside `IDLE`; it is not accepted, not dropped.
- Reset, including mid-write-back or mid-refill:
  - FSM → `IDLE`, all valid and dirty bits → 0, `cnt` → 0.
  - Partial memory traffic is abandoned. Tags and data are not reset.

## Timing
- Reset values: `req_ready`=0 during reset, 1 in `IDLE` after. `resp_valid`=0, `resp_rdata`=0, all `da_*`=0, all `mem_req_*`=0.
- Hit latency: acceptance at edge N → `resp_valid` high in cycle N+2.
- Clean-miss latency: 2 (request) + 16 beats + memory latency + 2.
- A dirty miss adds 16 × (1 read cycle + ≥1 send cycle).
- Once `mem_req_valid` is raised, it and its address/data stay stable until `mem_req_ready`.
- Back-to-back requests: next acceptance is possible in the cycle after `RESP`.

## Configuration
- `DCACHE_CTRL_STATS_EN` defined: adds outputs `stat_hits`, `stat_misses`, `stat_writebacks` (32 bits each, wrapping, async-reset to 0).
  - Hits and misses are counted on first `LOOKUP` only; replays are not counted.
  - Write-backs are counted per line.
- Undefined: no counters, no stat ports.

## Structure
- `dcache_pkg` holds:
  - `TAG_W`=3, `IDX_W`=10, `OFF_W`=4, `ADDR_W`=17, `DATA_W`=32.
  - Address-field extraction functions.
  - State enum `dcache_state_t`.
- Sub-module `dcache_tag_store` holds the tag/valid/dirty arrays. It has a combinational lookup port and a write port, and performs the valid/dirty async clear.

## Test plan
- Reset, then load 0x00010 → miss; one burst read at 0x00010 with 16 beats 0xA0..0xAF; `resp_rdata`=0xA0; repeat load hits with `resp_valid` 2 cycles after acceptance.
- Store 0x00013 ← 0xDEADBEEF (line present) → hit, no memory traffic; load 0x00013 returns 0xDEADBEEF.
- Load 0x04013 (same index, tag 1) after the dirty store → 16 writes at 0x00010..0x0001F with word 3 = 0xDEADBEEF, then refill at 0x04010.
- `mem_req_ready` held low 5 cycles during write-back → `mem_req_addr` and `mem_req_wdata` stable; no word skipped or duplicated.
- `rst_n` asserted at refill beat 7 → `IDLE`; the next load to the same line misses and re-requests the full burst.
- With `DCACHE_CTRL_STATS_EN` defined, after the above sequence the counters match the hit, miss and write-back counts.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared widths, address-field helpers and controller state encoding for the
// direct-mapped write-back data cache.
package dcache_pkg;

    localparam int TAG_W  = 3;
    localparam int IDX_W  = 10;
    localparam int OFF_W  = 4;
    localparam int ADDR_W = 17;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB_RD,
        WB_SEND,
        RF_REQ,
        RF_WAIT,
        RESP
    } dcache_state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return a[OFF_W +: IDX_W];
    endfunction

    function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
        return a[OFF_W-1:0];
    endfunction

endpackage

// File: rtl/dcache_tag_store.sv
// Per-line tag/valid/dirty state: combinational lookup, one write port, and an
// asynchronous clear of valid/dirty (tags are left untouched by reset).
module dcache_tag_store
    import dcache_pkg::*;
#(
    parameter int LINES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic             rd_valid_o,
    output logic             rd_dirty_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic             wr_dirty_i
);

    logic [TAG_W-1:0] tag_q [LINES];
    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
        end
    end

    // Every write installs or keeps a line, so valid is always set on write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
            dirty_q[wr_idx_i] <= wr_dirty_i;
        end
    end

    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_dirty_o = dirty_q[rd_idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Data-cache miss controller: lookup, dirty-victim write-back, burst refill.
// Optional hit/miss/write-back counters under DCACHE_CTRL_STATS_EN.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES = 1024,
    parameter int WORDS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              da_en,
    output logic              da_we,
    output logic [IDX_W-1:0]  da_index,
    output logic [OFF_W-1:0]  da_offset,
    output logic [DATA_W-1:0] da_wdata,
    input  logic [DATA_W-1:0] da_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DCACHE_CTRL_STATS_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses,
    output logic [31:0]       stat_writebacks
`endif
);

    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(WORDS - 1);

    dcache_state_t     state_q, state_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic              replay_q, replay_d;
    logic              wb_first_q, wb_first_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wb_data_q;

    logic [TAG_W-1:0]  tag, lk_tag, ts_wtag;
    logic [IDX_W-1:0]  idx;
    logic              lk_valid, lk_dirty, hit, ts_we, ts_wdirty;

    assign tag = addr_tag(addr_q);
    assign idx = addr_idx(addr_q);
    assign hit = lk_valid && (lk_tag == tag);

    dcache_tag_store #(.LINES(LINES)) u_tags (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx_i   (idx),
        .rd_tag_o   (lk_tag),
        .rd_valid_o (lk_valid),
        .rd_dirty_o (lk_dirty),
        .wr_en_i    (ts_we),
        .wr_idx_i   (idx),
        .wr_tag_i   (ts_wtag),
        .wr_dirty_i (ts_wdirty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            replay_q   <= 1'b0;
            wb_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            replay_q   <= replay_d;
            wb_first_q <= wb_first_d;
        end
    end

    // The RAM word is only guaranteed on the first send cycle; keep a copy for stalls.
    always_ff @(posedge clk) begin
        if (req_valid && req_ready) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
        if (wb_first_q) begin
            wb_data_q <= da_rdata;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        replay_d      = replay_q;
        wb_first_d    = 1'b0;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_rdata    = '0;
        da_en         = 1'b0;
        da_we         = 1'b0;
        da_index      = '0;
        da_offset     = '0;
        da_wdata      = '0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        ts_we         = 1'b0;
        ts_wtag       = tag;
        ts_wdirty     = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = rst_n;
                if (req_valid && rst_n) begin
                    state_d  = LOOKUP;
                    replay_d = 1'b0;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    da_en     = 1'b1;
                    da_index  = idx;
                    da_offset = addr_off(addr_q);
                    if (we_q) begin
                        da_we     = 1'b1;
                        da_wdata  = wdata_q;
                        ts_we     = 1'b1;
                        ts_wdirty = 1'b1;
                    end
                    state_d = RESP;
                end else if (lk_valid && lk_dirty) begin
                    cnt_d   = '0;
                    state_d = WB_RD;
                end else begin
                    state_d = RF_REQ;
                end
            end
            WB_RD: begin
                da_en      = 1'b1;
                da_index   = idx;
                da_offset  = cnt_q;
                wb_first_d = 1'b1;
                state_d    = WB_SEND;
            end
            WB_SEND: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {lk_tag, idx, cnt_q};
                mem_req_wdata = wb_first_q ? da_rdata : wb_data_q;
                if (mem_req_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_OFF) begin
                        ts_we     = 1'b1;
                        ts_wtag   = lk_tag;
                        ts_wdirty = 1'b0;
                        state_d   = RF_REQ;
                    end else begin
                        state_d = WB_RD;
                    end
                end
            end
            RF_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {tag, idx, {OFF_W{1'b0}}};
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = RF_WAIT;
                end
            end
            RF_WAIT: begin
                if (mem_rvalid) begin
                    da_en     = 1'b1;
                    da_we     = 1'b1;
                    da_index  = idx;
                    da_offset = cnt_q;
                    da_wdata  = mem_rdata;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LAST_OFF) begin
                        ts_we    = 1'b1;
                        replay_d = 1'b1;
                        state_d  = LOOKUP;
                    end
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = we_q ? '0 : da_rdata;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef DCACHE_CTRL_STATS_EN
    logic [31:0] hits_q, misses_q, wbs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hits_q   <= '0;
            misses_q <= '0;
            wbs_q    <= '0;
        end else begin
            if (state_q == LOOKUP && !replay_q) begin
                if (hit) hits_q <= hits_q + 1'b1;
                else     misses_q <= misses_q + 1'b1;
            end
            if (state_q == WB_SEND && mem_req_ready && cnt_q == LAST_OFF) begin
                wbs_q <= wbs_q + 1'b1;
            end
        end
    end

    assign stat_hits       = hits_q;
    assign stat_misses     = misses_q;
    assign stat_writebacks = wbs_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: architectural memory/cache model, memory
// responder with stall and burst refill, and an attached data-array RAM.
`timescale 1ns/1ps
module tb_dcache_ctrl;
    import dcache_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 0, req_ready, req_we = 0;
    logic [16:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        da_en, da_we;
    logic [9:0]  da_index;
    logic [3:0]  da_offset;
    logic [31:0] da_wdata, da_rdata;
    logic        mem_req_valid, mem_req_ready = 0, mem_req_we;
    logic [16:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_rvalid = 0;
    logic [31:0] mem_rdata = '0;
`ifdef DCACHE_CTRL_STATS_EN
    logic [31:0] stat_hits, stat_misses, stat_writebacks;
`endif

    dcache_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .da_en(da_en), .da_we(da_we), .da_index(da_index), .da_offset(da_offset),
        .da_wdata(da_wdata), .da_rdata(da_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef DCACHE_CTRL_STATS_EN
        , .stat_hits(stat_hits), .stat_misses(stat_misses),
        .stat_writebacks(stat_writebacks)
`endif
    );

    logic [31:0] ram [0:1023][0:15];
    always @(posedge clk) begin
        if (da_en) begin
            if (da_we) ram[da_index][da_offset] <= da_wdata;
            else       da_rdata <= ram[da_index][da_offset];
        end
    end

    int n_vec = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Architectural model: main-memory image and the core's view of memory.
    logic [31:0] mem_img [int];
    logic [31:0] arch [int];
    bit          mvalid [1024];
    bit          mdirty [1024];
    int          mtag   [1024];
    int          m_hits = 0, m_misses = 0, m_wbs = 0;

    function automatic logic [31:0] init_val(input int a);
        return 32'hA0 + 32'(a & 15) + (32'((a >> 4) - 1) << 8);
    endfunction
    function automatic logic [31:0] rd_mem(input int a);
        return mem_img.exists(a) ? mem_img[a] : init_val(a);
    endfunction
    function automatic logic [31:0] rd_arch(input int a);
        return arch.exists(a) ? arch[a] : rd_mem(a);
    endfunction

    int          exp_wr_a[$], exp_rd_a[$];
    logic [31:0] exp_wr_d[$];
    int          wb_log_a[$];
    logic [31:0] wb_log_d[$];
    int          last_rd_a = -1, beats_sent = 0, wb_seen = 0, stall_left = 0;
    bit          stall_arm = 0, junk_beat = 0;

    // Memory responder and bus-protocol checker.
    bit          burst_on = 0, pend = 0;
    int          burst_base = 0, burst_beat = 0, burst_wait = 0;
    logic [16:0] p_addr;
    logic [31:0] p_wdata;
    logic        p_we;
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_req_ready = 0; mem_rvalid = 0; mem_rdata = '0;
            burst_on = 0; pend = 0; stall_left = 0;
        end else begin
            if (pend) begin
                chk("hold_valid", 32'(mem_req_valid), 32'd1);
                chk("hold_we",    32'(mem_req_we), 32'(p_we));
                chk("hold_addr",  32'(mem_req_addr), 32'(p_addr));
                chk("hold_wdata", mem_req_wdata, p_wdata);
            end
            if (mem_req_valid && mem_req_we && stall_arm && wb_seen == 3) begin
                stall_left = 5;
                stall_arm  = 0;
            end
            mem_req_ready = mem_req_valid && (stall_left == 0);
            if (mem_req_valid && stall_left > 0) stall_left--;
            pend = mem_req_valid && !mem_req_ready;
            p_addr = mem_req_addr; p_wdata = mem_req_wdata; p_we = mem_req_we;
            if (mem_req_valid && mem_req_ready) begin
                if (mem_req_we) begin
                    if (exp_wr_a.size() == 0) begin
                        chk("unexpected_write", 32'(mem_req_addr), 32'hFFFFFFFF);
                    end else begin
                        chk("wb_addr", 32'(mem_req_addr), 32'(exp_wr_a.pop_front()));
                        chk("wb_data", mem_req_wdata, exp_wr_d.pop_front());
                    end
                    mem_img[int'(mem_req_addr)] = mem_req_wdata;
                    wb_log_a.push_back(int'(mem_req_addr));
                    wb_log_d.push_back(mem_req_wdata);
                    wb_seen++;
                end else begin
                    if (exp_rd_a.size() == 0)
                        chk("unexpected_refill", 32'(mem_req_addr), 32'hFFFFFFFF);
                    else
                        chk("rf_addr", 32'(mem_req_addr), 32'(exp_rd_a.pop_front()));
                    last_rd_a  = int'(mem_req_addr);
                    burst_on   = 1; burst_base = int'(mem_req_addr);
                    burst_beat = 0; burst_wait = 3;
                end
            end
            mem_rvalid = 0; mem_rdata = '0;
            if (burst_on) begin
                if (burst_wait > 0) burst_wait--;
                else begin
                    mem_rvalid = 1;
                    mem_rdata  = rd_mem(burst_base + burst_beat);
                    burst_beat++;
                    beats_sent = burst_beat;
                    if (burst_beat == 16) burst_on = 0;
                end
            end else if (junk_beat) begin
                mem_rvalid = 1;
                mem_rdata  = 32'hBAD0BAD0;
            end
        end
    end

    task automatic reset_model();
        for (int i = 0; i < 1024; i++) begin mvalid[i] = 0; mdirty[i] = 0; end
        arch.delete();
        exp_wr_a.delete(); exp_wr_d.delete(); exp_rd_a.delete();
        m_hits = 0; m_misses = 0; m_wbs = 0;
    endtask

    task automatic check_reset_vals(input string tag_s);
        chk({tag_s, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag_s, "_resp"}, {31'd0, resp_valid} | resp_rdata, 32'd0);
        chk({tag_s, "_da"}, 32'({da_en, da_we, da_index, da_offset}) | da_wdata, 32'd0);
        chk({tag_s, "_mem"}, 32'({mem_req_valid, mem_req_we, mem_req_addr}) | mem_req_wdata, 32'd0);
    endtask

    task automatic access(input bit we, input int a, input logic [31:0] wd,
                          input int abort_beat, output int lat, output logic [31:0] rd);
        int idx, tg;
        bit hit, seen;
        logic [31:0] exp_rd;
        idx = (a >> 4) & 1023;
        tg  = (a >> 14) & 7;
        hit = mvalid[idx] && (mtag[idx] == tg);
        exp_rd = we ? 32'd0 : rd_arch(a);
        if (hit) m_hits++;
        else begin
            m_misses++;
            if (mvalid[idx] && mdirty[idx]) begin
                m_wbs++;
                for (int k = 0; k < 16; k++) begin
                    exp_wr_a.push_back((mtag[idx] << 14) | (idx << 4) | k);
                    exp_wr_d.push_back(rd_arch((mtag[idx] << 14) | (idx << 4) | k));
                end
            end
            exp_rd_a.push_back((tg << 14) | (idx << 4));
        end
        beats_sent = 0;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = req_ready;
        end
        chk("req_ready_wait", 32'(seen), 32'd1);
        req_valid = 1; req_we = we; req_addr = 17'(a); req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 0;
        lat = 0; seen = 0; rd = '0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (abort_beat >= 0 && beats_sent >= abort_beat) begin
                #2 rst_n = 0;
                reset_model();
                @(negedge clk);
                check_reset_vals("abort_rst");
                @(negedge clk);
                #1 rst_n = 1;
                return;
            end
            if (resp_valid) begin seen = 1; rd = resp_rdata; end
        end
        chk("resp_seen", 32'(seen), 32'd1);
        chk("resp_rdata", rd, exp_rd);
        if (hit) chk("hit_latency", 32'(lat), 32'd2);
        chk("no_pending_traffic", 32'(exp_wr_a.size() + exp_rd_a.size()), 32'd0);
        @(negedge clk);
        chk("resp_pulse", 32'(resp_valid), 32'd0);
        chk("ready_after_resp", 32'(req_ready), 32'd1);
        if (!hit) begin mtag[idx] = tg; mvalid[idx] = 1; mdirty[idx] = 0; end
        if (we) begin arch[a] = wd; mdirty[idx] = 1; end
    endtask

    initial begin
        int lat;
        logic [31:0] rd;
        reset_model();
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        #1 rst_n = 1;
        @(negedge clk);
        chk("ready_out_of_reset", 32'(req_ready), 32'd1);

        access(0, 'h00010, 0, -1, lat, rd);
        chk("first_load_lit", rd, 32'h000000A0);
        chk("first_refill_addr_lit", 32'(last_rd_a), 32'h00010);
        access(0, 'h00010, 0, -1, lat, rd);
        chk("hit_lat_lit", 32'(lat), 32'd2);
        access(0, 'h0001F, 0, -1, lat, rd);
        chk("hit_word15_lit", rd, 32'h000000AF);

        junk_beat = 1;
        repeat (3) @(negedge clk);
        junk_beat = 0;
        access(1, 'h00013, 32'hDEADBEEF, -1, lat, rd);
        chk("store_resp_zero_lit", rd, 32'd0);
        access(0, 'h00013, 0, -1, lat, rd);
        chk("store_readback_lit", rd, 32'hDEADBEEF);

        wb_log_a.delete(); wb_log_d.delete(); wb_seen = 0; stall_arm = 1;
        access(0, 'h04013, 0, -1, lat, rd);
        chk("conflict_load_lit", rd, 32'h000400A3);
        chk("wb_count_lit", 32'(wb_log_a.size()), 32'd16);
        for (int k = 0; k < 16 && k < wb_log_a.size(); k++)
            chk("wb_seq_lit", 32'(wb_log_a[k]), 32'h10 + 32'(k));
        if (wb_log_d.size() > 3) chk("wb_word3_lit", wb_log_d[3], 32'hDEADBEEF);
        chk("refill_after_wb_lit", 32'(last_rd_a), 32'h04010);
        access(0, 'h00013, 0, -1, lat, rd);

        access(1, 'h00025, 32'h12345678, -1, lat, rd);
        access(0, 'h00025, 0, -1, lat, rd);
        access(0, 'h04025, 0, -1, lat, rd);
        access(0, 'h00025, 0, -1, lat, rd);
        chk("store_miss_wb_lit", rd, 32'h12345678);

        access(0, 'h08050, 0, 7, lat, rd);
        @(negedge clk);
        chk("ready_after_abort", 32'(req_ready), 32'd1);
        last_rd_a = -1;
        access(0, 'h08053, 0, -1, lat, rd);
        chk("rerefill_addr_lit", 32'(last_rd_a), 32'h08050);
        chk("rerefill_beats_lit", 32'(beats_sent), 32'd16);
        access(0, 'h08050, 0, -1, lat, rd);
        access(1, 'h0805F, 32'hCAFEF00D, -1, lat, rd);
        access(0, 'h0C05F, 0, -1, lat, rd);

`ifdef DCACHE_CTRL_STATS_EN
        chk("stat_hits", stat_hits, 32'(m_hits));
        chk("stat_misses", stat_misses, 32'(m_misses));
        chk("stat_writebacks", stat_writebacks, 32'(m_wbs));
        chk("stat_misses_lit", stat_misses, 32'd2);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

endmodule
